fifo_dest: RTL and testbench

Per-destination receive FIFO placed directly downstream of the destination demultiplexer; one instance is attached to each destination output (d0, d1). It absorbs the demux's registered valid/data stream, buffers up to DEPTH words, and releases them in order on a pop request with one-cycle registered read latency. Occupancy and threshold flags (full, empty, almost_full, almost_empty) are exported to the QoS flow-control logic.

---
 rtl/fifo_dest.sv | 125 ++++++++++++
 tb/tb_fifo_dest.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_dest.sv
// fifo_dest: per-destination receive FIFO downstream of the destination demux.
// Buffers up to DEPTH words written by push, returns them in order on pop with
// one-cycle registered read latency, and exports occupancy/threshold flags for
// the QoS flow-control logic.
// Optional feature macro: FIFO_DEST_ERR_EN adds a sticky overflow/underflow
// error output; without it, overflow and underflow are silently ignored.
module fifo_dest #(
  parameter int BW        = 6,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [BW-1:0]     data_in,
  input  logic              push,
  input  logic              pop,
  output logic [BW-1:0]     data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_count
`ifdef FIFO_DEST_ERR_EN
  ,
  output logic              error
`endif
);

  // Thresholds sized to the counter so every flag compare is width-matched.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

  logic [BW-1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [BW-1:0]     r_data_out;
  logic              r_valid_out;

  logic              w_full;
  logic              w_empty;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic [ADDR_W:0]   w_count_nxt;

  // Status decodes taken straight from the registered count.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A pop on empty is rejected (no write-through); a push on full is accepted
  // only when a same-cycle pop frees the slot.
  assign w_pop_ok  = pop && !w_empty;
  assign w_push_ok = push && (!w_full || w_pop_ok);

  // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
  always_comb begin
    // NOTE: default assigned first so every path drives w_count_nxt and no latch is inferred.
    w_count_nxt = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write; pointer wrap is the natural ADDR_W-bit overflow.
  // NOTE: the array has no reset on purpose; contents are don't-care until written, and leaving it out keeps it plain storage.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_data_out  <= r_mem[r_rd_ptr];
        r_valid_out <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

`ifdef FIFO_DEST_ERR_EN
  logic r_error;

  // Sticky error: overflow (push on full with no pop) or underflow (pop on empty).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error <= 1'b0;
    end else if ((push && w_full && !pop) || (pop && w_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`endif

  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_fifo_dest.sv
// tb_fifo_dest: self-checking bench for fifo_dest. Directed scenarios followed
// by random push/pop traffic, all compared cycle by cycle against a queue-based
// reference model, with asynchronous reset applied mid-stream.
module tb_fifo_dest;

  localparam int BW        = 6;
  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 2;
  localparam int AF_THRESH = 3;
  localparam int AE_THRESH = 1;

  logic              clk;
  logic              reset_L;
  logic [BW-1:0]     data_in;
  logic              push;
  logic              pop;
  logic [BW-1:0]     data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fifo_count;
`ifdef FIFO_DEST_ERR_EN
  logic              error;
`endif

  fifo_dest #(
    .BW(BW), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .data_in(data_in),
    .push(push),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .fifo_count(fifo_count)
`ifdef FIFO_DEST_ERR_EN
    ,
    .error(error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: contents in order, last read word, valid, sticky error.
  int q[$];
  int m_dout;
  int m_valid;
  int m_err;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".data_out"},  int'(data_out),     m_dout);
    check({tag, ".valid_out"}, int'(valid_out),    m_valid);
    check({tag, ".count"},     int'(fifo_count),   n);
    check({tag, ".full"},      int'(full),         int'(n == DEPTH));
    check({tag, ".empty"},     int'(empty),        int'(n == 0));
    check({tag, ".a_full"},    int'(almost_full),  int'(n >= AF_THRESH));
    check({tag, ".a_empty"},   int'(almost_empty), int'(n <= AE_THRESH));
`ifdef FIFO_DEST_ERR_EN
    check({tag, ".error"},     int'(error),        m_err);
`endif
  endtask

  function automatic void model_reset();
    q.delete();
    m_dout  = 0;
    m_valid = 0;
    m_err   = 0;
  endfunction

  // One clock: drive after the falling edge, update the model at the rising
  // edge from pre-edge state, compare 1 time unit later.
  task automatic step(input string tag, input bit p_push, input bit p_pop, input int d);
    bit was_full, was_empty, pop_ok, push_ok;
    push    = p_push;
    pop     = p_pop;
    data_in = BW'(d);
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    pop_ok    = p_pop && !was_empty;
    push_ok   = p_push && (!was_full || pop_ok);
    if ((p_push && was_full && !p_pop) || (p_pop && was_empty)) m_err = 1;
    if (pop_ok) begin
      m_dout  = q.pop_front();
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    if (push_ok) q.push_back(d & ((1 << BW) - 1));
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    reset_L = 1'b1;
  endtask

  initial begin
    int nxt;
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_L = 1'b1;

    // Fill with 0x11..0x14, then drain.
    for (int i = 0; i < 4; i++) step("fill", 1, 0, 'h11 + i);
    for (int i = 0; i < 4; i++) step("drain", 0, 1, 0);
    step("idle", 0, 0, 0);

    // Overflow: push onto full with no pop is dropped.
    for (int i = 0; i < 4; i++) step("fill2", 1, 0, 'h11 + i);
    step("ovf", 1, 0, 'h20);
    for (int i = 0; i < 4; i++) step("drain2", 0, 1, 0);

    // Full with simultaneous push and pop keeps count at DEPTH.
    async_reset("rst_a");
    for (int i = 0; i < 4; i++) step("fill3", 1, 0, 'h11 + i);
    step("full_pp", 1, 1, 'h25);
    check("full_pp_lit", int'(data_out), 'h11);
    for (int i = 0; i < 5; i++) step("drain3", 0, 1, 0);
    check("last_lit", int'(data_out), 'h25);

    // Empty with simultaneous push and pop: pop rejected, push accepted.
    async_reset("rst_b");
    step("empty_pp", 1, 1, 'h05);
    check("empty_pp_valid", int'(valid_out), 0);
    step("empty_pp_pop", 0, 1, 0);
    check("empty_pp_lit", int'(data_out), 'h05);

    // Interleaved traffic across pointer wrap, then reset mid-stream.
    nxt = 'h30;
    for (int i = 0; i < 6; i++) begin
      step("wrap_push", 1, 0, nxt);
      nxt++;
      step("wrap_pp", 1, 1, nxt);
      nxt++;
    end
    async_reset("rst_mid");
    step("post_push", 1, 0, 'h0A);
    step("post_pop", 0, 1, 0);
    check("post_lit", int'(data_out), 'h0A);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset("rst_rand");
      else step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, (1 << BW) - 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
